// File: rtl/onehot_stim_pkg.sv
// Shared definitions for the one-hot stimulus generator: state encoding,
// default timing constants and elaboration-time helpers.
package onehot_stim_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_HOLD   = 10;
   localparam int DEF_SETTLE = 10;
   localparam int DEF_DWELL  = 10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HOLD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_STEP   = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/stim_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, i.e. during
// the last cycle of a phase that was loaded with (length - 1).
module stim_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/onehot_stim_gen.sv
// Drives a reset pulse and a walking one-hot pattern into a downstream FSM,
// captures its response at the end of each dwell and flags any mismatch.
module onehot_stim_gen
   import onehot_stim_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HOLD   = DEF_HOLD,
   parameter int SETTLE = DEF_SETTLE,
   parameter int DWELL  = DEF_DWELL,
   localparam int IDX_W = (WIDTH > 1) ? clog2(WIDTH) : 1,
   localparam int CAP_W = WIDTH * WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] resp_outputs,
   input  logic [CAP_W-1:0] exp_capture,
   output logic             stim_reset,
   output logic [WIDTH-1:0] stim_inputs,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] step_idx,
   output logic [CAP_W-1:0] capture,
   output logic             mismatch
);

   localparam int CNT_W = clog2(max3(HOLD, SETTLE, DWELL) + 1);
   localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   step_nxt;
   logic [CAP_W-1:0]   cap_nxt;
   logic               mm_nxt;
   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic               tmr_tc;

   stim_phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load    (tmr_load),
      .load_val(tmr_val),
      .tc      (tmr_tc)
   );

   // Phases are loaded with (length - 1) so tc marks their final cycle.
   always_comb begin
      state_nxt = state;
      step_nxt  = step_idx;
      cap_nxt   = capture;
      mm_nxt    = mismatch;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               state_nxt = ST_HOLD;
               tmr_load  = 1'b1;
               tmr_val   = CNT_W'(HOLD - 1);
               step_nxt  = '0;
               cap_nxt   = '0;
               mm_nxt    = 1'b0;
            end
         end
         ST_HOLD: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (tmr_tc) begin
               state_nxt = ST_SETTLE;
               tmr_load  = 1'b1;
               tmr_val   = CNT_W'(SETTLE - 1);
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (tmr_tc) begin
               state_nxt = ST_STEP;
               tmr_load  = 1'b1;
               tmr_val   = CNT_W'(DWELL - 1);
               step_nxt  = '0;
            end
         end
         ST_STEP: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (tmr_tc) begin
               cap_nxt[int'(step_idx)*WIDTH +: WIDTH] = resp_outputs;
               if (step_idx == LAST_IDX) begin
                  // Compare against the capture including the slice just taken,
                  // so mismatch is valid in the same cycle as done.
                  state_nxt = ST_DONE;
                  mm_nxt    = (cap_nxt != exp_capture);
               end else begin
                  step_nxt = step_idx + IDX_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(DWELL - 1);
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from next-state values and registered.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         stim_reset  <= 1'b0;
         stim_inputs <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         step_idx    <= '0;
         capture     <= '0;
         mismatch    <= 1'b0;
      end else begin
         state       <= state_nxt;
         stim_reset  <= (state_nxt == ST_HOLD);
         stim_inputs <= (state_nxt == ST_STEP) ? (ONE_HOT0 << step_nxt) : '0;
         busy        <= (state_nxt == ST_HOLD) || (state_nxt == ST_SETTLE) ||
                        (state_nxt == ST_STEP);
         done        <= (state_nxt == ST_DONE);
         step_idx    <= step_nxt;
         capture     <= cap_nxt;
         mismatch    <= mm_nxt;
      end
   end

endmodule

// File: tb/tb_onehot_stim_gen.sv
// Bench for onehot_stim_gen: timeline model of a run checked every cycle,
// plus directed runs with literal expectations.
module tb_onehot_stim_gen;

   localparam int W = 4;
   localparam int H = 10;
   localparam int S = 10;
   localparam int D = 10;
   localparam int T_STEP = H + S;
   localparam int T_DONE = H + S + W * D;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [W-1:0]     glitch = '0;
   logic [W-1:0]     resp_outputs;
   logic [W*W-1:0]   exp_capture = '0;
   logic             stim_reset;
   logic [W-1:0]     stim_inputs;
   logic             busy;
   logic             done;
   logic [1:0]       step_idx;
   logic [W*W-1:0]   capture;
   logic             mismatch;

   // Downstream FSM stand-in: echoes its inputs, with noise between sample points.
   assign resp_outputs = stim_inputs ^ glitch;

   onehot_stim_gen #(
      .WIDTH (W),
      .HOLD  (H),
      .SETTLE(S),
      .DWELL (D)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .resp_outputs(resp_outputs),
      .exp_capture (exp_capture),
      .stim_reset  (stim_reset),
      .stim_inputs (stim_inputs),
      .busy        (busy),
      .done        (done),
      .step_idx    (step_idx),
      .capture     (capture),
      .mismatch    (mismatch)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int c0 = 0;
   int done_cnt = 0;
   int done_lat = -1;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Model: a run is a timeline; m_k is the number of edges since start was taken.
   bit             m_act = 1'b0;
   int             m_k = 0;
   logic [W*W-1:0] m_cap = '0;
   int             m_step = 0;
   bit             m_mm = 1'b0;

   always @(posedge clk) begin : model
      bit a;
      int k;
      logic [W*W-1:0] c;
      int s;
      bit mm;
      a = m_act; k = m_k; c = m_cap; s = m_step; mm = m_mm;
      if (!reset) begin
         a = 1'b0; k = 0; c = '0; s = 0; mm = 1'b0;
      end else if (a) begin
         if (k == T_DONE || abort) begin
            a = 1'b0;
         end else begin
            k = k + 1;
            if (k > T_STEP && (k - T_STEP) % D == 0)
               c[((k - T_STEP) / D - 1) * W +: W] = resp_outputs;
            if (k < T_STEP) s = 0;
            else s = ((k - T_STEP) / D > W - 1) ? W - 1 : (k - T_STEP) / D;
            if (k == T_DONE) mm = (c != exp_capture);
         end
      end else if (start && !abort) begin
         a = 1'b1; k = 0; c = '0; s = 0; mm = 1'b0;
      end
      m_act <= a; m_k <= k; m_cap <= c; m_step <= s; m_mm <= mm;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("stim_reset", stim_reset, m_act && m_k < H);
         check("stim_inputs", stim_inputs,
               (m_act && m_k >= T_STEP && m_k < T_DONE) ? (1 << ((m_k - T_STEP) / D)) : 0);
         check("busy", busy, m_act && m_k < T_DONE);
         check("done", done, m_act && m_k == T_DONE);
         check("step_idx", step_idx, m_step);
         check("capture", capture, m_cap);
         check("mismatch", mismatch, m_mm);
         if (done === 1'b1) begin
            done_cnt++;
            done_lat = cyc - c0;
         end
      end
   end

   // One sequence: start taken at edge N; ab/rs/rt = edge index (after N) at which
   // abort / a repeated start / reset-low is sampled, -1 for none.
   task automatic run(input logic [W*W-1:0] exp, input int ab, input int rs, input int rt,
                      output int d_delta);
      int d0;
      exp_capture = exp;
      d0 = done_cnt;
      done_lat = -1;
      c0 = cyc;
      start = 1'b1;
      for (int e = 0; e <= 75; e++) begin
         @(negedge clk);
         start = (e + 1 == rs);
         abort = (e + 1 == ab);
         reset = !(e + 1 == rt);
         if ((e + 1) > T_STEP && (e + 1) <= T_DONE && ((e + 1 - T_STEP) % D == 0))
            glitch = '0;
         else
            glitch = W'($urandom);
         if (ab >= 0 && e == ab - 1) check("pre_abort_stim", stim_inputs, 4'h2);
         if (ab >= 0 && e == ab) begin
            check("abort_stim", stim_inputs, 4'h0);
            check("abort_busy", busy, 1'b0);
         end
         if (rt >= 0 && e == rt) begin
            check("rst_busy", busy, 1'b0);
            check("rst_stim", stim_inputs, 4'h0);
            check("rst_capture", capture, 16'h0000);
         end
      end
      start = 1'b0; abort = 1'b0; reset = 1'b1; glitch = '0;
      d_delta = done_cnt - d0;
   endtask

   initial begin
      int dd;
      reset = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_capture", capture, 16'h0000);
      reset = 1'b1;
      repeat (100) @(negedge clk);
      check("quiet_done_cnt", done_cnt, 0);
      check("quiet_stim_reset", stim_reset, 1'b0);

      run(16'h8421, -1, -1, -1, dd);
      check("run1_done_pulses", dd, 1);
      check("run1_done_latency", done_lat, 61);
      check("run1_capture", capture, 16'h8421);
      check("run1_mismatch", mismatch, 1'b0);

      run(16'h8420, -1, -1, -1, dd);
      check("run2_done_pulses", dd, 1);
      check("run2_mismatch", mismatch, 1'b1);

      run(16'h8421, 35, -1, -1, dd);
      check("abort_done_pulses", dd, 0);
      check("abort_capture", capture, 16'h0001);
      check("abort_mismatch", mismatch, 1'b0);

      run(16'h8421, -1, 30, -1, dd);
      check("restart_done_pulses", dd, 1);
      check("restart_done_latency", done_lat, 61);
      check("restart_capture", capture, 16'h8421);

      run(16'h8421, -1, -1, 40, dd);
      check("midrst_done_pulses", dd, 0);
      check("midrst_step_idx", step_idx, 2'd0);

      run(16'h8421, -1, -1, -1, dd);
      check("fresh_done_pulses", dd, 1);
      check("fresh_capture", capture, 16'h8421);
      check("fresh_mismatch", mismatch, 1'b0);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
